// File: rtl/conv_layer_sequencer.sv
// Layer controller for the 32x32 conv engine: walks output pixels in row-major order,
// requests each input patch, starts the engine and addresses every result batch.
module conv_layer_sequencer #(
  parameter int ADDR_W = 24,
  parameter int DIM_W  = 10,
  parameter int PIX_W  = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DIM_W-1:0]         cfg_h_in,
  input  logic [DIM_W-1:0]         cfg_w_in,
  input  logic [10:0]              cfg_c_in,
  input  logic [10:0]              cfg_c_out,
  input  logic [3:0]               cfg_kernel,
  input  logic [1:0]               cfg_stride,
  input  logic [1:0]               cfg_pad,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err,
  output logic                     patch_req,
  output logic signed [11:0]       patch_iy,
  output logic signed [11:0]       patch_ix,
  input  logic                     patch_ack,
  output logic                     eng_start,
  output logic [10:0]              eng_c_in,
  output logic [10:0]              eng_c_out,
  output logic [3:0]               eng_kernel,
  input  logic                     eng_out_valid,
  input  logic [8:0]               eng_out_ch_base,
  input  logic [5:0]               eng_out_count,
  input  logic                     eng_done,
  output logic                     wr_valid,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [5:0]               wr_count,
  output logic [PIX_W-1:0]         pix_count
);

  typedef enum logic [2:0] {IDLE, CHECK, PATCH_REQ, ENG_START, ENG_WAIT, NEXT, DONE} state_t;

  state_t              state_reg, state_next;
  logic [DIM_W-1:0]    h_reg, w_reg;
  logic [10:0]         c_in_reg, c_out_reg;
  logic [3:0]          k_reg;
  logic [1:0]          s_reg, p_reg;
  logic signed [11:0]  iy_reg, ix_reg;
  logic [ADDR_W-1:0]   pix_base_reg;
  logic [PIX_W-1:0]    pix_count_reg;
  logic                err_reg;

  logic signed [11:0]  pad_s, stride_s, k_s, h_s, w_s;
  logic                cfg_bad, ix_fits, iy_fits;

  always_comb begin
    pad_s    = signed'({10'd0, p_reg});
    stride_s = signed'({10'd0, s_reg});
    k_s      = signed'({8'd0, k_reg});
    h_s      = signed'(12'(h_reg));
    w_s      = signed'(12'(w_reg));
    cfg_bad  = (k_reg != 4'd1 && k_reg != 4'd3) || (s_reg != 2'd1 && s_reg != 2'd2) ||
               (p_reg > 2'd1) || (h_reg == '0) || (w_reg == '0) ||
               (c_in_reg == '0) || (c_out_reg == '0) || (c_out_reg > 11'd512) ||
               (h_s + 2 * pad_s < k_s) || (w_s + 2 * pad_s < k_s);
    // Window stepping compares the far edge of the next window against the padded extent.
    ix_fits  = (ix_reg + stride_s + k_s) <= (w_s + pad_s);
    iy_fits  = (iy_reg + stride_s + k_s) <= (h_s + pad_s);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      h_reg         <= '0;
      w_reg         <= '0;
      c_in_reg      <= '0;
      c_out_reg     <= '0;
      k_reg         <= '0;
      s_reg         <= '0;
      p_reg         <= '0;
      iy_reg        <= '0;
      ix_reg        <= '0;
      pix_base_reg  <= '0;
      pix_count_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (start) begin
          h_reg     <= cfg_h_in;
          w_reg     <= cfg_w_in;
          c_in_reg  <= cfg_c_in;
          c_out_reg <= cfg_c_out;
          k_reg     <= cfg_kernel;
          s_reg     <= cfg_stride;
          p_reg     <= cfg_pad;
        end
        CHECK: begin
          err_reg <= cfg_bad;
          if (!cfg_bad) begin
            iy_reg        <= -pad_s;
            ix_reg        <= -pad_s;
            pix_base_reg  <= '0;
            pix_count_reg <= '0;
          end
        end
        NEXT: begin
          pix_base_reg  <= pix_base_reg + ADDR_W'(c_out_reg);
          pix_count_reg <= pix_count_reg + 1'b1;
          if (ix_fits) begin
            ix_reg <= ix_reg + stride_s;
          end else if (iy_fits) begin
            ix_reg <= -pad_s;
            iy_reg <= iy_reg + stride_s;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    cfg_err    = 1'b0;
    patch_req  = 1'b0;
    eng_start  = 1'b0;
    wr_valid   = 1'b0;
    wr_addr    = '0;
    wr_count   = '0;
    case (state_reg)
      IDLE: if (start) state_next = CHECK;
      CHECK: begin
        busy       = 1'b1;
        state_next = cfg_bad ? DONE : PATCH_REQ;
      end
      PATCH_REQ: begin
        busy      = 1'b1;
        patch_req = 1'b1;
        if (patch_ack) state_next = ENG_START;
      end
      ENG_START: begin
        busy       = 1'b1;
        eng_start  = 1'b1;
        state_next = ENG_WAIT;
      end
      ENG_WAIT: begin
        busy = 1'b1;
        if (eng_out_valid) begin
          wr_valid = 1'b1;
          wr_addr  = pix_base_reg + ADDR_W'(eng_out_ch_base);
          wr_count = eng_out_count;
        end
        if (eng_done) state_next = NEXT;
      end
      NEXT: begin
        busy       = 1'b1;
        state_next = (ix_fits || iy_fits) ? PATCH_REQ : DONE;
      end
      DONE: begin
        done       = 1'b1;
        cfg_err    = err_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign patch_iy   = iy_reg;
  assign patch_ix   = ix_reg;
  assign eng_c_in   = c_in_reg;
  assign eng_c_out  = c_out_reg;
  assign eng_kernel = k_reg;
  assign pix_count  = pix_count_reg;

endmodule

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
Layer-level controller for the 32x32 conv engine. It walks every output pixel of one conv layer in row-major order. For each pixel it requests a patch gather, starts the engine and supplies the output-buffer write address for every 32-channel result batch the engine emits. It sits in dpu_top between the layer-config registers, the patch gatherer, the conv engine and the output activation buffer. It uses step-based padding/stride arithmetic, so no divider is needed.

Parameters:
ADDR_W, 24, output-buffer byte address width
DIM_W, 10, width of feature-map height/width
PIX_W, 20, width of the processed-pixel counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse: latch config and run the layer; ignored unless idle
cfg_h_in  in  DIM_W  input height
cfg_w_in  in  DIM_W  input width
cfg_c_in  in  11  input channels
cfg_c_out  in  11  output channels
cfg_kernel  in  4  kernel size, 1 or 3
cfg_stride  in  2  stride, 1 or 2
cfg_pad  in  2  padding, 0 or 1
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at end of layer (also on config error)
cfg_err  out  1  one-cycle pulse with done when the config was rejected
patch_req  out  1  patch gather request, level, held until ack
patch_iy  out  12 signed  top-left input row of the window (may be -pad)
patch_ix  out  12 signed  top-left input column of the window
patch_ack  in  1  gatherer finished filling the patch buffer
eng_start  out  1  one-cycle engine start pulse
eng_c_in  out  11  latched c_in
eng_c_out  out  11  latched c_out
eng_kernel  out  4  latched kernel size
eng_out_valid  in  1  engine result batch valid
eng_out_ch_base  in  9  first channel of the batch
eng_out_count  in  6  valid channels in the batch
eng_done  in  1  engine finished the pixel
wr_valid  out  1  output-buffer write enable (combinational)
wr_addr  out  ADDR_W  byte address of the batch's first channel
wr_count  out  6  bytes to write
pix_count  out  PIX_W  pixels completed in the current layer

Behaviour:
- Reset: state IDLE. busy, done, cfg_err, patch_req, eng_start, wr_valid = 0. patch_iy/ix = 0, pix_count = 0, eng_* = 0. Reset mid-layer abandons the run immediately; no further eng_start or patch_req is issued.
- States: IDLE, CHECK, PATCH_REQ, ENG_START, ENG_WAIT, NEXT, DONE.
- IDLE: on start, latch all cfg_* into internal regs (eng_* drive from these regs) and go to CHECK.
- CHECK: reject if any of the following holds:
  - kernel not in {1,3};
  - stride not in {1,2};
  - pad > 1;
  - any dimension or channel count is 0;
  - c_out > 512;
  - h_in+2*pad < k or w_in+2*pad < k.
  On reject: pulse done and cfg_err the next cycle and return to IDLE; no patch_req or eng_start is issued.
  On accept: iy = ix = -pad, pix_base = 0, pix_count = 0; go to PATCH_REQ.
- PATCH_REQ: patch_req = 1 with patch_iy/ix = iy/ix. patch_req stays high until the cycle patch_ack is sampled high, then drops the next cycle. Go to ENG_START.
- ENG_START: eng_start = 1 for exactly one cycle, then ENG_WAIT.
- ENG_WAIT, on each eng_out_valid in the same cycle:
  - wr_valid = 1;
  - wr_addr = pix_base + eng_out_ch_base;
  - wr_count = eng_out_count.
  Engine data is aligned with wr_valid, so no delay is needed. eng_out_valid outside ENG_WAIT is ignored (wr_valid = 0). On eng_done, go to NEXT; eng_out_valid and eng_done in the same cycle still produce the write.
- NEXT: pix_base += c_out and pix_count += 1, then step the window:
  - if ix+stride+k <= w_in+pad: ix += stride;
  - else if iy+stride+k <= h_in+pad: ix = -pad, iy += stride;
  - else: go to DONE.
  Otherwise return to PATCH_REQ.
- DONE: done = 1 for one cycle, busy = 0 the same cycle, then IDLE.
- Output extents: h_out = floor((h_in+2p-k)/s)+1, w_out likewise. The number of eng_start pulses equals h_out*w_out. wr_addr = (pixel_index*c_out + ch_base) mod 2^ADDR_W.
- All window coordinate arithmetic is 12-bit signed. pix_base is ADDR_W unsigned and wraps.
- Per-pixel overhead beyond gather and engine time: 3 cycles (PATCH_REQ min 1, ENG_START, NEXT).

Test Plan:
- h=w=4, k3 s1 p1, c_in 16, c_out 40 -> 16 eng_start pulses. First patch (-1,-1), last (2,2). Each pixel gives writes (base, 32) and (base+32, 8). Pixel 5 writes addr 200 and 232. done after the 16th eng_done, pix_count = 16.
- h=w=5, k3 s2 p1 -> patch iy/ix sequence over {-1,1,3}, 9 pixels, final pix_count = 9.
- h=2, w=3, k1 s1 p0, c_out 8 -> 6 pixels at (0,0)..(1,2), wr_addr 0,8,...,40.
- patch_ack delayed 7 cycles -> patch_req held 7 cycles with stable coords; eng_start only after ack; eng_out_valid injected during PATCH_REQ produces no wr_valid.
- Config errors: kernel=2, or h_in=1 with k3 p0 -> cfg_err and done pulse 2 cycles after start; no patch_req; busy low after. start pulsed during busy -> ignored.
- rst asserted during ENG_WAIT of pixel 3 -> all outputs 0 next cycle, state IDLE; a new start runs a full clean layer from (-pad,-pad).
